// File: rtl/issue_queue_age_select.sv
// Out-of-order issue queue: slot allocation, CDB wakeup,
// oldest-ready-first select from an age matrix, branch kill and flush.
module issue_queue_age_select #(
  parameter int QUEUE_DEPTH = 8,
  parameter int NUM_CDB     = 2,
  parameter int PREG_W      = 6,
  parameter int BMASK_W     = 4,
  parameter int DATA_W      = 64,
  localparam int BB_W  = $clog2(BMASK_W),
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [DATA_W-1:0]         disp_payload,
  input  logic                      disp_use_rs1,
  input  logic                      disp_use_rs2,
  input  logic [PREG_W-1:0]         disp_rs1_tag,
  input  logic [PREG_W-1:0]         disp_rs2_tag,
  input  logic                      disp_rs1_rdy,
  input  logic                      disp_rs2_rdy,
  input  logic [BMASK_W-1:0]        disp_bmask,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0] cdb_tag,
  input  logic                      br_resolve,
  input  logic                      br_mispred,
  input  logic [BB_W-1:0]           br_bit,
  input  logic                      flush,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [DATA_W-1:0]         issue_payload,
  output logic [PREG_W-1:0]         issue_rs1_tag,
  output logic [PREG_W-1:0]         issue_rs2_tag,
  output logic                      issue_use_rs1,
  output logic                      issue_use_rs2,
  output logic [BMASK_W-1:0]        issue_bmask,
  output logic [OCC_W-1:0]          occupancy
);

  logic [QUEUE_DEPTH-1:0] valid_q;
  logic [QUEUE_DEPTH-1:0] use1_q;
  logic [QUEUE_DEPTH-1:0] use2_q;
  logic [QUEUE_DEPTH-1:0] rdy1_q;
  logic [QUEUE_DEPTH-1:0] rdy2_q;
  logic [PREG_W-1:0]      tag1_q  [QUEUE_DEPTH];
  logic [PREG_W-1:0]      tag2_q  [QUEUE_DEPTH];
  logic [BMASK_W-1:0]     bmask_q [QUEUE_DEPTH];
  logic [DATA_W-1:0]      pay_q   [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] older_q [QUEUE_DEPTH];

  logic [QUEUE_DEPTH-1:0] hit1;
  logic [QUEUE_DEPTH-1:0] hit2;
  logic                   din_hit1;
  logic                   din_hit2;
  logic [QUEUE_DEPTH-1:0] kill;
  logic [QUEUE_DEPTH-1:0] ready;
  logic [QUEUE_DEPTH-1:0] grant;
  logic [QUEUE_DEPTH-1:0] alloc_oh;
  logic [QUEUE_DEPTH-1:0] valid_n;
  logic [OCC_W-1:0]       occ_n;
  logic [BMASK_W-1:0]     bclr;
  logic                   br_kill;
  logic                   br_ok;
  logic                   disp_drop;
  logic                   alloc;
  logic                   fire;

  assign br_kill    = br_resolve & br_mispred;
  assign br_ok      = br_resolve & ~br_mispred;
  assign disp_ready = (occupancy != OCC_W'(QUEUE_DEPTH));
  assign disp_drop  = flush | (br_kill & disp_bmask[br_bit]);
  assign alloc      = disp_valid & disp_ready & ~disp_drop & ~rst;
  assign issue_valid = |grant;
  assign fire       = issue_valid & issue_ready;

  always_comb begin
    bclr = '1;
    if (br_ok) bclr[br_bit] = 1'b0;
  end

  always_comb begin
    hit1     = '0;
    hit2     = '0;
    din_hit1 = 1'b0;
    din_hit2 = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p]) begin
        if (cdb_tag[p*PREG_W +: PREG_W] == disp_rs1_tag)
          din_hit1 = 1'b1;
        if (cdb_tag[p*PREG_W +: PREG_W] == disp_rs2_tag)
          din_hit2 = 1'b1;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          if (cdb_tag[p*PREG_W +: PREG_W] == tag1_q[i])
            hit1[i] = 1'b1;
          if (cdb_tag[p*PREG_W +: PREG_W] == tag2_q[i])
            hit2[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      kill[i]  = br_kill & bmask_q[i][br_bit];
      ready[i] = valid_q[i] & ~kill[i]
               & (~use1_q[i] | rdy1_q[i] | hit1[i])
               & (~use2_q[i] | rdy2_q[i] | hit2[i]);
    end
  end

  // An entry is blocked by any ready entry that is older than it.
  always_comb begin
    logic blk;
    blk   = 1'b0;
    grant = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < QUEUE_DEPTH; j++)
        if (ready[j] && older_q[j][i]) blk = 1'b1;
      grant[i] = ready[i] & ~blk & ~flush;
    end
  end

  always_comb begin
    issue_payload = '0;
    issue_rs1_tag = '0;
    issue_rs2_tag = '0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
    issue_bmask   = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (grant[i]) begin
        issue_payload = issue_payload | pay_q[i];
        issue_rs1_tag = issue_rs1_tag | tag1_q[i];
        issue_rs2_tag = issue_rs2_tag | tag2_q[i];
        issue_use_rs1 = issue_use_rs1 | use1_q[i];
        issue_use_rs2 = issue_use_rs2 | use2_q[i];
        issue_bmask   = issue_bmask | (bmask_q[i] & bclr);
      end
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      alloc_oh[i] = ~valid_q[i] & ~found;
      found       = found | ~valid_q[i];
    end
  end

  always_comb begin
    occ_n = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      valid_n[i] = (valid_q[i] & ~(fire & grant[i]) & ~kill[i])
                 | (alloc & alloc_oh[i]);
      if (flush) valid_n[i] = 1'b0;
      occ_n = occ_n + OCC_W'(valid_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_n;
      occupancy <= occ_n;
    end
  end

  // Payload, tags and age carry no reset; valid qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (alloc && alloc_oh[i]) begin
        pay_q[i]   <= disp_payload;
        use1_q[i]  <= disp_use_rs1;
        use2_q[i]  <= disp_use_rs2;
        tag1_q[i]  <= disp_rs1_tag;
        tag2_q[i]  <= disp_rs2_tag;
        rdy1_q[i]  <= disp_rs1_rdy | din_hit1;
        rdy2_q[i]  <= disp_rs2_rdy | din_hit2;
        bmask_q[i] <= disp_bmask & bclr;
      end else begin
        rdy1_q[i]  <= rdy1_q[i] | (use1_q[i] & hit1[i]);
        rdy2_q[i]  <= rdy2_q[i] | (use2_q[i] & hit2[i]);
        bmask_q[i] <= bmask_q[i] & bclr;
      end
      for (int j = 0; j < QUEUE_DEPTH; j++) begin
        if (alloc) begin
          if (alloc_oh[i])
            older_q[i][j] <= 1'b0;
          else if (alloc_oh[j])
            older_q[i][j] <= valid_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_age_select.sv
// Directed bench for issue_queue_age_select: age order, wakeup,
// out-of-order issue, full/reuse, branch resolve, flush and reset.
module tb_issue_queue_age_select;

  localparam int QD = 8;
  localparam int NC = 2;
  localparam int PW = 6;
  localparam int BW = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic disp_valid, disp_ready;
  logic [DW-1:0] disp_payload;
  logic disp_use_rs1, disp_use_rs2;
  logic [PW-1:0] disp_rs1_tag, disp_rs2_tag;
  logic disp_rs1_rdy, disp_rs2_rdy;
  logic [BW-1:0] disp_bmask;
  logic [NC-1:0] cdb_valid;
  logic [NC*PW-1:0] cdb_tag;
  logic br_resolve, br_mispred;
  logic [1:0] br_bit;
  logic flush;
  logic issue_valid, issue_ready;
  logic [DW-1:0] issue_payload;
  logic [PW-1:0] issue_rs1_tag, issue_rs2_tag;
  logic issue_use_rs1, issue_use_rs2;
  logic [BW-1:0] issue_bmask;
  logic [3:0] occupancy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_queue_age_select dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_payload(disp_payload),
    .disp_use_rs1(disp_use_rs1), .disp_use_rs2(disp_use_rs2),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_bmask(disp_bmask),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .br_resolve(br_resolve), .br_mispred(br_mispred),
    .br_bit(br_bit), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_bmask(issue_bmask), .occupancy(occupancy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid   = 1'b0;
    disp_payload = '0;
    disp_use_rs1 = 1'b0;
    disp_use_rs2 = 1'b0;
    disp_rs1_tag = '0;
    disp_rs2_tag = '0;
    disp_rs1_rdy = 1'b0;
    disp_rs2_rdy = 1'b0;
    disp_bmask   = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    br_resolve   = 1'b0;
    br_mispred   = 1'b0;
    br_bit       = '0;
    flush        = 1'b0;
    issue_ready  = 1'b0;
  endtask

  task automatic put(input logic [63:0] pl,
                     input logic u1,
                     input logic [PW-1:0] t1,
                     input logic r1,
                     input logic [BW-1:0] bm);
    disp_valid   = 1'b1;
    disp_payload = pl;
    disp_use_rs1 = u1;
    disp_rs1_tag = t1;
    disp_rs1_rdy = r1;
    disp_use_rs2 = 1'b0;
    disp_rs2_tag = '0;
    disp_rs2_rdy = 1'b0;
    disp_bmask   = bm;
  endtask

  task automatic iss(input string tag, input logic [63:0] pl);
    chk({tag, "_v"}, 64'(issue_valid), 64'd1);
    chk({tag, "_pl"}, issue_payload, pl);
  endtask

  initial begin
    logic [63:0] exp_pl;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_drdy", 64'(disp_ready), 64'd1);
    chk("rst_ivld", 64'(issue_valid), 64'd0);

    // age ordering
    put(64'hA, 1'b0, '0, 1'b0, 4'b0); tick();
    put(64'hB, 1'b0, '0, 1'b0, 4'b0); tick();
    put(64'hC, 1'b0, '0, 1'b0, 4'b0); tick();
    idle();
    issue_ready = 1'b1;
    #1;
    chk("age_occ3", 64'(occupancy), 64'd3);
    iss("age_a", 64'hA);
    tick();
    chk("age_occ2", 64'(occupancy), 64'd2);
    iss("age_b", 64'hB);
    tick();
    chk("age_occ1", 64'(occupancy), 64'd1);
    iss("age_c", 64'hC);
    tick();
    chk("age_occ0", 64'(occupancy), 64'd0);
    chk("age_empty", 64'(issue_valid), 64'd0);

    // wakeup bypass
    idle();
    put(64'h20, 1'b1, 6'h12, 1'b0, 4'b0); tick();
    idle();
    #1;
    chk("wk_wait", 64'(issue_valid), 64'd0);
    cdb_valid = 2'b10;
    cdb_tag   = {6'h12, 6'h00};
    put(64'h21, 1'b1, 6'h12, 1'b0, 4'b0);
    #1;
    iss("wk_same", 64'h20);
    tick();
    idle();
    issue_ready = 1'b1;
    #1;
    iss("wk_old", 64'h20);
    tick();
    iss("wk_byp", 64'h21);
    tick();
    chk("wk_occ0", 64'(occupancy), 64'd0);

    // out-of-order
    idle();
    put(64'h30, 1'b1, 6'd5, 1'b0, 4'b0); tick();
    put(64'h31, 1'b0, '0, 1'b0, 4'b0); tick();
    idle();
    issue_ready = 1'b1;
    #1;
    iss("ooo_young", 64'h31);
    tick();
    chk("ooo_block", 64'(issue_valid), 64'd0);
    chk("ooo_occ1", 64'(occupancy), 64'd1);
    cdb_valid = 2'b01;
    cdb_tag   = {6'h00, 6'd5};
    #1;
    iss("ooo_old", 64'h30);
    tick();
    idle();
    #1;
    chk("ooo_occ0", 64'(occupancy), 64'd0);

    // full and slot reuse
    for (int i = 0; i < QD; i++) begin
      put(64'h40 + 64'(i), 1'b0, '0, 1'b0, 4'b0);
      tick();
    end
    put(64'h99, 1'b0, '0, 1'b0, 4'b0);
    #1;
    chk("full_drdy", 64'(disp_ready), 64'd0);
    chk("full_occ", 64'(occupancy), 64'd8);
    tick();
    chk("full_nowr", 64'(occupancy), 64'd8);
    issue_ready = 1'b1;
    #1;
    iss("full_iss", 64'h40);
    chk("full_same", 64'(disp_ready), 64'd0);
    tick();
    idle();
    #1;
    chk("full_occ7", 64'(occupancy), 64'd7);
    chk("full_free", 64'(disp_ready), 64'd1);
    put(64'h50, 1'b0, '0, 1'b0, 4'b0);
    tick();
    idle();
    issue_ready = 1'b1;
    for (int i = 0; i < QD; i++) begin
      exp_pl = (i < 7) ? 64'h41 + 64'(i) : 64'h50;
      #1;
      iss($sformatf("drain%0d", i), exp_pl);
      tick();
    end
    chk("drain_occ", 64'(occupancy), 64'd0);
    idle();

    // branch mispredict
    put(64'h60, 1'b0, '0, 1'b0, 4'b0010); tick();
    put(64'h61, 1'b0, '0, 1'b0, 4'b0001); tick();
    put(64'h62, 1'b0, '0, 1'b0, 4'b0010);
    br_resolve = 1'b1;
    br_mispred = 1'b1;
    br_bit     = 2'd1;
    #1;
    iss("mp_sel", 64'h61);
    tick();
    idle();
    #1;
    chk("mp_occ", 64'(occupancy), 64'd1);
    chk("mp_bm", 64'(issue_bmask), 64'h1);
    iss("mp_surv", 64'h61);
    issue_ready = 1'b1;
    tick();
    idle();

    // branch correct
    put(64'h60, 1'b0, '0, 1'b0, 4'b0010); tick();
    put(64'h61, 1'b0, '0, 1'b0, 4'b0001); tick();
    put(64'h62, 1'b0, '0, 1'b0, 4'b0010);
    br_resolve = 1'b1;
    br_mispred = 1'b0;
    br_bit     = 2'd1;
    #1;
    chk("ok_bm_same", 64'(issue_bmask), 64'h0);
    tick();
    idle();
    issue_ready = 1'b1;
    #1;
    chk("ok_occ", 64'(occupancy), 64'd3);
    iss("ok_p", 64'h60);
    chk("ok_bm_p", 64'(issue_bmask), 64'h0);
    tick();
    iss("ok_q", 64'h61);
    chk("ok_bm_q", 64'(issue_bmask), 64'h1);
    tick();
    iss("ok_r", 64'h62);
    chk("ok_bm_r", 64'(issue_bmask), 64'h0);
    tick();
    idle();

    // flush with dispatch
    for (int i = 0; i < 5; i++) begin
      put(64'h70 + 64'(i), 1'b0, '0, 1'b0, 4'b0);
      tick();
    end
    put(64'h77, 1'b0, '0, 1'b0, 4'b0);
    flush       = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("fl_occ5", 64'(occupancy), 64'd5);
    chk("fl_force", 64'(issue_valid), 64'd0);
    tick();
    idle();
    #1;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_ivld", 64'(issue_valid), 64'd0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      put(64'h80 + 64'(i), 1'b0, '0, 1'b0, 4'b0);
      tick();
    end
    rst = 1'b1;
    put(64'h88, 1'b0, '0, 1'b0, 4'b0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("mrst_occ", 64'(occupancy), 64'd0);
    chk("mrst_ivld", 64'(issue_valid), 64'd0);
    chk("mrst_drdy", 64'(disp_ready), 64'd1);
    put(64'h90, 1'b0, '0, 1'b0, 4'b0);
    tick();
    idle();
    #1;
    iss("mrst_new", 64'h90);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
